jtopl_reg_bank: RTL and testbench

Parametrised successor to the OPL operator/channel register front-end. Supports 9-channel (OPL/OPL2) or 18-channel (OPL3) banks. Takes raw chip writes (9-bit address, 8-bit data) and holds them pending until the time-multiplexed slot counter reaches the target slot or channel. Presents per-slot operator and channel configuration to the PG/EG/OP pipeline, including OPL3 4-op pair flags.

---
 rtl/jtopl_reg_pkg.sv | 68 ++++++
 rtl/jtopl_reg_dec.sv | 69 ++++++
 rtl/jtopl_reg_bank.sv | 279 +++++++++++++++++++++++++++
 tb/tb_jtopl_reg_bank.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jtopl_reg_pkg.sv
// jtopl_reg_pkg: shared definitions for the OPL register bank.
//   - chip address bases for operator, channel and 4-op registers
//   - field widths and the packed operator / channel entry layouts
//   - pair_of(): maps a channel to its OPL3 4-op pair index
// An operator entry is op_cfg_t (32 bits) plus a WAVW-bit wave select held
// alongside it (34 bits at WAVW=2). A channel entry is ch_cfg_t (18 bits).
package jtopl_reg_pkg;

    localparam logic [8:0] A_OP20 = 9'h020;
    localparam logic [8:0] A_OP40 = 9'h040;
    localparam logic [8:0] A_OP60 = 9'h060;
    localparam logic [8:0] A_OP80 = 9'h080;
    localparam logic [8:0] A_CHA0 = 9'h0A0;
    localparam logic [8:0] A_CHB0 = 9'h0B0;
    localparam logic [8:0] A_CHC0 = 9'h0C0;
    localparam logic [8:0] A_OPE0 = 9'h0E0;
    localparam logic [8:0] A_EN4  = 9'h104;

    localparam int FNUM_W = 10;
    localparam int BLK_W  = 3;
    localparam int FB_W   = 3;
    localparam int MULT_W = 4;
    localparam int KSL_W  = 2;
    localparam int TL_W   = 6;
    localparam int RATE_W = 4;
    localparam int EN4_W  = 6;

    typedef enum logic [3:0] {
        K_NONE, K_OP20, K_OP40, K_OP60, K_OP80, K_OPE0,
        K_CHA0, K_CHB0, K_CHC0, K_EN4
    } reg_kind_t;

    typedef struct packed {
        logic              am;
        logic              vib;
        logic              egt;
        logic              ksr;
        logic [MULT_W-1:0] mult;
        logic [KSL_W-1:0]  ksl;
        logic [TL_W-1:0]   tl;
        logic [RATE_W-1:0] ar;
        logic [RATE_W-1:0] dr;
        logic [RATE_W-1:0] sl;
        logic [RATE_W-1:0] rr;
    } op_cfg_t;

    typedef struct packed {
        logic [FNUM_W-1:0] fnum;
        logic [BLK_W-1:0]  block;
        logic              keyon;
        logic [FB_W-1:0]   fb;
        logic              con;
    } ch_cfg_t;

    // Returns {hit, k}: hit when the channel belongs to a 4-op pair k (0..5).
    // Pair k covers channels k%3 and k%3+3 within bank k/3.
    function automatic logic [3:0] pair_of(input logic [4:0] ch);
        logic [4:0] l;
        logic [2:0] k;
        logic       hit;
        l   = (ch >= 5'd9) ? ch - 5'd9 : ch;
        hit = (l < 5'd6);
        k   = (l < 5'd3) ? l[2:0] : 3'(l - 5'd3);
        if (ch >= 5'd9) k = k + 3'd3;
        return {hit, k};
    endfunction

endpackage

// File: rtl/jtopl_reg_dec.sv
// jtopl_reg_dec: combinational address decoder.
//   addr  : 9-bit chip address (bit 8 = bank)
//   kind  : which register family the address hits (K_NONE if invalid)
//   tgt   : slot the write must wait for (channel writes use ch*2)
//   valid : kind != K_NONE
module jtopl_reg_dec
    import jtopl_reg_pkg::*;
#(
    parameter int CH = 9,
    parameter int SW = $clog2(2*CH)
) (
    input  logic [8:0]    addr,
    output reg_kind_t     kind,
    output logic [SW-1:0] tgt,
    output logic          valid
);

    logic [7:0] o;
    logic       bank;
    logic       bank_ok;
    logic [4:0] r;
    logic [2:0] s;
    logic [2:0] smod;
    logic [5:0] ch_op;
    logic [5:0] ch_ch;
    logic       op_ok;
    logic       ch_ok;

    always_comb begin
        o       = addr[7:0];
        bank    = addr[8];
        bank_ok = !bank || (CH == 18);
        r       = o[4:0];
        s       = r[2:0];
        smod    = (s >= 3'd3) ? s - 3'd3 : s;
        // Three channels per 8-offset group, modulators first then carriers.
        ch_op   = ({4'b0, r[4:3]} * 6'd3) + {3'b0, smod} + (bank ? 6'd9 : 6'd0);
        ch_ch   = {2'b0, o[3:0]} + (bank ? 6'd9 : 6'd0);
        op_ok   = (r[4:3] != 2'b11) && (s < 3'd6);
        ch_ok   = (o[3:0] <= 4'd8);
        kind    = K_NONE;
        tgt     = '0;
        if (addr == A_EN4) begin
            if (CH == 18) kind = K_EN4;
        end else if (bank_ok) begin
            if (op_ok) begin
                case (o[7:5])
                    A_OP20[7:5]: kind = K_OP20;
                    A_OP40[7:5]: kind = K_OP40;
                    A_OP60[7:5]: kind = K_OP60;
                    A_OP80[7:5]: kind = K_OP80;
                    A_OPE0[7:5]: kind = K_OPE0;
                    default:     kind = K_NONE;
                endcase
                if (kind != K_NONE) tgt = SW'({ch_op, (s >= 3'd3)});
            end
            if (ch_ok) begin
                case (o[7:4])
                    A_CHA0[7:4]: begin kind = K_CHA0; tgt = SW'({ch_ch, 1'b0}); end
                    A_CHB0[7:4]: begin kind = K_CHB0; tgt = SW'({ch_ch, 1'b0}); end
                    A_CHC0[7:4]: begin kind = K_CHC0; tgt = SW'({ch_ch, 1'b0}); end
                    default: ;
                endcase
            end
        end
        valid = (kind != K_NONE);
    end

endmodule

// File: rtl/jtopl_reg_bank.sv
// jtopl_reg_bank: OPL/OPL3 operator and channel register front-end.
// Chip writes are held pending until the slot counter reaches the target
// slot, then committed; per-slot configuration is presented one cen after
// the counter value it belongs to.
// Ports: clk, rst_n (async low), cen; addr/din/wr chip write; busy (write
//   pending); zero/slot_idx/ch_idx/op presented slot; channel fields fnum,
//   block, keyon, fb, con, pair4; operator fields am..wav.
// Optional: JTOPL_REG_READBACK_EN adds rd/rdata/rd_valid, sharing the
//   pending slot with writes.
module jtopl_reg_bank
    import jtopl_reg_pkg::*;
#(
    parameter  int CH   = 9,
    parameter  int WAVW = 2,
    localparam int SW   = $clog2(2*CH),
    localparam int CW   = $clog2(CH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cen,
    input  logic [8:0]      addr,
    input  logic [7:0]      din,
    input  logic            wr,
    output logic            busy,
    output logic            zero,
    output logic [SW-1:0]   slot_idx,
    output logic [CW-1:0]   ch_idx,
    output logic            op,
    output logic [9:0]      fnum,
    output logic [2:0]      block,
    output logic            keyon,
    output logic [2:0]      fb,
    output logic            con,
    output logic            pair4,
    output logic            am,
    output logic            vib,
    output logic            egt,
    output logic            ksr,
    output logic [3:0]      mult,
    output logic [1:0]      ksl,
    output logic [5:0]      tl,
    output logic [3:0]      ar,
    output logic [3:0]      dr,
    output logic [3:0]      sl,
    output logic [3:0]      rr,
    output logic [WAVW-1:0] wav
`ifdef JTOPL_REG_READBACK_EN
    ,
    input  logic            rd,
    output logic [7:0]      rdata,
    output logic            rd_valid
`endif
);

    localparam logic [SW-1:0] LAST = SW'(2*CH-1);
    localparam logic [SW-1:0] ONE  = SW'(1);

    logic [SW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    reg_kind_t       pk_q, pk_d;
    logic [SW-1:0]   pt_q, pt_d;
    logic [7:0]      pd_q, pd_d;
    op_cfg_t         op_mem_q [2*CH];
    op_cfg_t         op_mem_d [2*CH];
    logic [WAVW-1:0] wav_mem_q [2*CH];
    logic [WAVW-1:0] wav_mem_d [2*CH];
    ch_cfg_t         ch_mem_q [CH];
    ch_cfg_t         ch_mem_d [CH];
    logic [EN4_W-1:0] en4_q, en4_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic            zero_q, zero_d;
    op_cfg_t         p_op_q, p_op_d;
    logic [WAVW-1:0] p_wav_q, p_wav_d;
    ch_cfg_t         p_ch_q, p_ch_d;
    logic            p_pair_q, p_pair_d;

    reg_kind_t       dec_kind;
    logic [SW-1:0]   dec_tgt;
    logic            dec_valid;
    logic            hit, is_wr, accept, rd_req;
    op_cfg_t         op_new;
    logic [WAVW-1:0] wav_new;
    ch_cfg_t         ch_new;
    logic [3:0]      pinfo;

`ifdef JTOPL_REG_READBACK_EN
    logic            prd_q, prd_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            rdv_q, rdv_d;
    op_cfg_t         rop;
    ch_cfg_t         rch;
`endif

    jtopl_reg_dec #(.CH(CH), .SW(SW)) u_dec (
        .addr  (addr),
        .kind  (dec_kind),
        .tgt   (dec_tgt),
        .valid (dec_valid)
    );

    always_comb begin
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        pk_d      = pk_q;
        pt_d      = pt_q;
        pd_d      = pd_q;
        op_mem_d  = op_mem_q;
        wav_mem_d = wav_mem_q;
        ch_mem_d  = ch_mem_q;
        en4_d     = en4_q;
        slot_d    = slot_q;
        zero_d    = zero_q;
        p_op_d    = p_op_q;
        p_wav_d   = p_wav_q;
        p_ch_d    = p_ch_q;
        p_pair_d  = p_pair_q;

        if (cen) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ONE;

        // Invalid and 4-op enable writes retire on the first cen; the rest
        // wait for their slot (channel targets are already ch*2).
        hit = busy_q && cen && (pk_q == K_NONE || pk_q == K_EN4 || cnt_q == pt_q);
`ifdef JTOPL_REG_READBACK_EN
        is_wr  = hit && !prd_q;
        rd_req = rd;
`else
        is_wr  = hit;
        rd_req = 1'b0;
`endif

        op_new  = op_mem_q[pt_q];
        wav_new = wav_mem_q[pt_q];
        ch_new  = ch_mem_q[pt_q[SW-1:1]];
        case (pk_q)
            K_OP20: {op_new.am, op_new.vib, op_new.egt, op_new.ksr, op_new.mult} = pd_q;
            K_OP40: {op_new.ksl, op_new.tl} = pd_q;
            K_OP60: {op_new.ar, op_new.dr} = pd_q;
            K_OP80: {op_new.sl, op_new.rr} = pd_q;
            K_OPE0: wav_new = pd_q[WAVW-1:0];
            K_CHA0: ch_new.fnum[7:0] = pd_q;
            K_CHB0: {ch_new.keyon, ch_new.block, ch_new.fnum[9:8]} = pd_q[5:0];
            K_CHC0: {ch_new.fb, ch_new.con} = pd_q[3:0];
            default: ;
        endcase

        if (is_wr) begin
            op_mem_d[pt_q]         = op_new;
            wav_mem_d[pt_q]        = wav_new;
            ch_mem_d[pt_q[SW-1:1]] = ch_new;
            if (pk_q == K_EN4) en4_d = pd_q[5:0];
        end
        if (hit) busy_d = 1'b0;

        // busy_q gates acceptance, so a strobe on the commit edge is dropped.
        accept = (wr || rd_req) && !busy_q;
        if (accept) begin
            busy_d = 1'b1;
            pk_d   = dec_valid ? dec_kind : K_NONE;
            pt_d   = dec_tgt;
            pd_d   = din;
        end

        // Present from the post-commit arrays so a commit shows up for its
        // own slot on the same edge.
        pinfo = pair_of(5'(cnt_q[SW-1:1]));
        if (cen) begin
            slot_d   = cnt_q;
            zero_d   = (cnt_q == '0);
            p_op_d   = op_mem_d[cnt_q];
            p_wav_d  = wav_mem_d[cnt_q];
            p_ch_d   = ch_mem_d[cnt_q[SW-1:1]];
            p_pair_d = (CH == 18) && pinfo[3] && en4_q[pinfo[2:0]];
        end
    end

`ifdef JTOPL_REG_READBACK_EN
    always_comb begin
        prd_d   = prd_q;
        rdata_d = rdata_q;
        rdv_d   = 1'b0;
        rop     = op_mem_q[pt_q];
        rch     = ch_mem_q[pt_q[SW-1:1]];
        if (accept) prd_d = rd && !wr;
        if (hit && prd_q) begin
            rdv_d = 1'b1;
            case (pk_q)
                K_OP20:  rdata_d = {rop.am, rop.vib, rop.egt, rop.ksr, rop.mult};
                K_OP40:  rdata_d = {rop.ksl, rop.tl};
                K_OP60:  rdata_d = {rop.ar, rop.dr};
                K_OP80:  rdata_d = {rop.sl, rop.rr};
                K_OPE0:  rdata_d = 8'(wav_mem_q[pt_q]);
                K_CHA0:  rdata_d = rch.fnum[7:0];
                K_CHB0:  rdata_d = {2'b00, rch.keyon, rch.block, rch.fnum[9:8]};
                K_CHC0:  rdata_d = {4'b0000, rch.fb, rch.con};
                K_EN4:   rdata_d = {2'b00, en4_q};
                default: rdata_d = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prd_q   <= 1'b0;
            rdata_q <= '0;
            rdv_q   <= 1'b0;
        end else begin
            prd_q   <= prd_d;
            rdata_q <= rdata_d;
            rdv_q   <= rdv_d;
        end
    end

    assign rdata    = rdata_q;
    assign rd_valid = rdv_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            pk_q     <= K_NONE;
            pt_q     <= '0;
            pd_q     <= '0;
            en4_q    <= '0;
            slot_q   <= '0;
            zero_q   <= 1'b0;
            p_op_q   <= '0;
            p_wav_q  <= '0;
            p_ch_q   <= '0;
            p_pair_q <= 1'b0;
            for (int i = 0; i < 2*CH; i++) begin
                op_mem_q[i]  <= '0;
                wav_mem_q[i] <= '0;
            end
            for (int i = 0; i < CH; i++) ch_mem_q[i] <= '0;
        end else begin
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            pk_q      <= pk_d;
            pt_q      <= pt_d;
            pd_q      <= pd_d;
            en4_q     <= en4_d;
            slot_q    <= slot_d;
            zero_q    <= zero_d;
            p_op_q    <= p_op_d;
            p_wav_q   <= p_wav_d;
            p_ch_q    <= p_ch_d;
            p_pair_q  <= p_pair_d;
            op_mem_q  <= op_mem_d;
            wav_mem_q <= wav_mem_d;
            ch_mem_q  <= ch_mem_d;
        end
    end

    assign busy     = busy_q;
    assign zero     = zero_q;
    assign slot_idx = slot_q;
    assign ch_idx   = slot_q[SW-1:1];
    assign op       = slot_q[0];
    assign fnum     = p_ch_q.fnum;
    assign block    = p_ch_q.block;
    assign keyon    = p_ch_q.keyon;
    assign fb       = p_ch_q.fb;
    assign con      = p_ch_q.con;
    assign pair4    = p_pair_q;
    assign am       = p_op_q.am;
    assign vib      = p_op_q.vib;
    assign egt      = p_op_q.egt;
    assign ksr      = p_op_q.ksr;
    assign mult     = p_op_q.mult;
    assign ksl      = p_op_q.ksl;
    assign tl       = p_op_q.tl;
    assign ar       = p_op_q.ar;
    assign dr       = p_op_q.dr;
    assign sl       = p_op_q.sl;
    assign rr       = p_op_q.rr;
    assign wav      = p_wav_q;

endmodule

// File: tb/tb_jtopl_reg_bank.sv
// Directed bench: one CH=9 and one CH=18 instance share clock, reset, cen,
// addr and din; each has its own write strobe.
module tb_jtopl_reg_bank;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cen = 1'b0;
    logic       wr9 = 1'b0;
    logic       wr18 = 1'b0;
    logic [8:0] addr = '0;
    logic [7:0] din = '0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic       busy9, zero9, op9, keyon9, con9, pair9, am9, vib9, egt9, ksr9;
    logic [4:0] slot9;
    logic [3:0] chi9, mult9, ar9, dr9, sl9, rr9;
    logic [9:0] fnum9;
    logic [2:0] block9, fb9;
    logic [1:0] ksl9, wav9;
    logic [5:0] tl9;

    logic       busy18, zero18, op18, keyon18, con18, pair18, am18, vib18, egt18, ksr18;
    logic [5:0] slot18;
    logic [4:0] chi18;
    logic [3:0] mult18, ar18, dr18, sl18, rr18;
    logic [9:0] fnum18;
    logic [2:0] block18, fb18;
    logic [1:0] ksl18, wav18;
    logic [5:0] tl18;

    logic [33:0] opv9, opv18;
    assign opv9  = {am9, vib9, egt9, ksr9, mult9, ksl9, tl9, ar9, dr9, sl9, rr9, wav9};
    assign opv18 = {am18, vib18, egt18, ksr18, mult18, ksl18, tl18, ar18, dr18, sl18, rr18, wav18};

    jtopl_reg_bank #(.CH(9), .WAVW(2)) u9 (
        .clk(clk), .rst_n(rst_n), .cen(cen), .addr(addr), .din(din), .wr(wr9),
        .busy(busy9), .zero(zero9), .slot_idx(slot9), .ch_idx(chi9), .op(op9),
        .fnum(fnum9), .block(block9), .keyon(keyon9), .fb(fb9), .con(con9), .pair4(pair9),
        .am(am9), .vib(vib9), .egt(egt9), .ksr(ksr9), .mult(mult9), .ksl(ksl9), .tl(tl9),
        .ar(ar9), .dr(dr9), .sl(sl9), .rr(rr9), .wav(wav9)
    );

    jtopl_reg_bank #(.CH(18), .WAVW(2)) u18 (
        .clk(clk), .rst_n(rst_n), .cen(cen), .addr(addr), .din(din), .wr(wr18),
        .busy(busy18), .zero(zero18), .slot_idx(slot18), .ch_idx(chi18), .op(op18),
        .fnum(fnum18), .block(block18), .keyon(keyon18), .fb(fb18), .con(con18), .pair4(pair18),
        .am(am18), .vib(vib18), .egt(egt18), .ksr(ksr18), .mult(mult18), .ksl(ksl18), .tl(tl18),
        .ar(ar18), .dr(dr18), .sl(sl18), .rr(rr18), .wav(wav18)
    );

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic w9(input logic [8:0] a, input logic [7:0] d);
        addr = a; din = d; wr9 = 1'b1;
        @(negedge clk);
        wr9 = 1'b0;
    endtask

    task automatic w18(input logic [8:0] a, input logic [7:0] d);
        addr = a; din = d; wr18 = 1'b1;
        @(negedge clk);
        wr18 = 1'b0;
    endtask

    task automatic idle9(input string tag);
        int n = 0;
        while (busy9 && n < 80) begin n++; @(negedge clk); end
        chk(tag, busy9, 0);
    endtask

    task automatic idle18(input string tag);
        int n = 0;
        while (busy18 && n < 80) begin n++; @(negedge clk); end
        chk(tag, busy18, 0);
    endtask

    task automatic slot9_at(input logic [4:0] s);
        int n = 0;
        while (slot9 !== s && n < 80) begin n++; @(negedge clk); end
        chk("slot9_wait", slot9, s);
    endtask

    task automatic slot18_at(input logic [5:0] s);
        int n = 0;
        while (slot18 !== s && n < 80) begin n++; @(negedge clk); end
        chk("slot18_wait", slot18, s);
    endtask

    initial begin
        int n;
        cen = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_busy9", busy9, 0);
        chk("rst_zero9", zero9, 0);
        chk("rst_slot9", slot9, 0);
        chk("rst_op9", opv9, 0);
        chk("rst_ch9", {fnum9, block9, keyon9, fb9, con9, pair9}, 0);
        chk("rst_busy18", busy18, 0);
        chk("rst_ch18", {fnum18, block18, keyon18, fb18, con18, pair18, slot18}, 0);
        rst_n = 1'b1;

        // 0x20=0x21 accepted with counter at 5 -> waits 13 cen for slot 0
        slot9_at(5'd4);
        w9(9'h020, 8'h21);
        n = 0;
        while (busy9 && n < 64) begin n++; @(negedge clk); end
        chk("busy_len", n, 13);
        chk("t1_slot", slot9, 0);
        chk("t1_zero", zero9, 1);
        chk("t1_mult", mult9, 1);
        chk("t1_egt", egt9, 1);
        chk("t1_am", am9, 0);

        // Gap offset 0x26: retired on next cen, nothing changes for 2 laps
        w9(9'h026, 8'hFF);
        chk("gap_busy_set", busy9, 1);
        @(negedge clk);
        chk("gap_busy_clr", busy9, 0);
        slot9_at(5'd0);
        for (int i = 0; i < 36; i++) begin
            chk("gap_lap_op", opv9, (i % 18 == 0) ? {4'b0010, 4'd1, 26'd0} : 34'd0);
            chk("gap_lap_zero", zero9, (i % 18 == 0));
            @(negedge clk);
        end

        // 0xC4=0x0B -> ch4 fb=5 con=1 at slot 8
        w9(9'h0C4, 8'h0B);
        idle9("c4_idle");
        slot9_at(5'd8);
        chk("c4_fb", fb9, 5);
        chk("c4_con", con9, 1);
        chk("c4_ch", chi9, 4);
        chk("c4_op", op9, 0);

        // 0x4B=0x85 -> ch3 carrier (slot 7) ksl=2 tl=5
        w9(9'h04B, 8'h85);
        idle9("4b_idle");
        slot9_at(5'd7);
        chk("4b_ksl", ksl9, 2);
        chk("4b_tl", tl9, 5);
        chk("4b_ch", chi9, 3);
        chk("4b_op", op9, 1);

        // 0xE0=0x07 -> wave masked to 2 bits
        w9(9'h0E0, 8'h07);
        idle9("e0_idle");
        slot9_at(5'd0);
        chk("e0_wav", wav9, 3);
        chk("e0_mult", mult9, 1);

        // Back-to-back strobes: second is dropped
        addr = 9'h060; din = 8'hA5; wr9 = 1'b1;
        @(negedge clk);
        din = 8'h3C;
        @(negedge clk);
        wr9 = 1'b0;
        idle9("dbl_idle");
        slot9_at(5'd0);
        chk("dbl_ar", ar9, 4'hA);
        chk("dbl_dr", dr9, 4'h5);

        // Accept with cen low; no commit until cen returns
        cen = 1'b0;
        w9(9'h080, 8'h12);
        chk("cen0_busy", busy9, 1);
        repeat (20) @(negedge clk);
        chk("cen0_hold", busy9, 1);
        cen = 1'b1;
        idle9("cen0_idle");
        slot9_at(5'd0);
        chk("cen0_sl", sl9, 1);
        chk("cen0_rr", rr9, 2);

        // CH=18 bank 1 channel 14
        w18(9'h1A5, 8'h34);
        idle18("a5_idle");
        w18(9'h1B5, 8'h2E);
        idle18("b5_idle");
        slot18_at(6'd28);
        chk("ch14m_fnum", fnum18, 10'h234);
        chk("ch14m_block", block18, 3);
        chk("ch14m_keyon", keyon18, 1);
        chk("ch14m_ch", chi18, 14);
        chk("ch14m_op", op18, 0);
        @(negedge clk);
        chk("ch14c_slot", slot18, 29);
        chk("ch14c_fnum", fnum18, 10'h234);
        chk("ch14c_op", op18, 1);
        slot18_at(6'd26);
        chk("ch13_fnum", fnum18, 0);
        chk("ch13_keyon", keyon18, 0);

        // 0x104 is invalid on CH=9
        w9(9'h104, 8'h3F);
        chk("en4_9_busy", busy9, 1);
        @(negedge clk);
        chk("en4_9_clr", busy9, 0);

        // 4-op pair 0 -> ch0 and ch3 only
        w18(9'h104, 8'h01);
        chk("en4_busy", busy18, 1);
        idle18("en4_idle");
        @(negedge clk);
        slot18_at(6'd0);
        for (int i = 0; i < 36; i++) begin
            chk("pair4_18", pair18, (i / 2 == 0) || (i / 2 == 3));
            chk("pair4_9", pair9, 0);
            @(negedge clk);
        end

        // Reset while a write is pending
        w9(9'h080, 8'hFF);
        chk("rstp_busy", busy9, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstp_busy0", busy9, 0);
        chk("rstp_op9", opv9, 0);
        chk("rstp_slot9", {slot9, zero9}, 0);
        chk("rstp_ch18", {fnum18, keyon18, pair18}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        slot9_at(5'd0);
        chk("rstp_zero", zero9, 1);
        chk("rstp_slrr", {sl9, rr9}, 0);
        chk("rstp_mult", mult9, 0);
        chk("rstp_idle", busy9, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
